// File: rtl/nested_sqrt_chain_pipe.sv
// Pipelined nested integer square root: res = isqrt(x0 + isqrt(x1 + ... + isqrt(x[N-1]))).
// Saturating adds between stages; the overflow flag travels with each token to the output.

module nested_sqrt_chain_pipe_isqrt #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] a,
    output logic             out_vld,
    output logic [WIDTH-1:0] y
);
    localparam int HW = WIDTH / 2;

    // Digit-by-digit root; the trailing register chain gives retiming room to balance it.
    function automatic logic [HW-1:0] isqrt_f(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] op;
        logic [WIDTH-1:0] rt;
        logic [WIDTH-1:0] bitv;
        op   = v;
        rt   = '0;
        bitv = {2'b01, {(WIDTH-2){1'b0}}};
        for (int i = 0; i < HW; i++) begin
            if (op >= rt + bitv) begin
                op = op - (rt + bitv);
                rt = (rt >> 1) + bitv;
            end else begin
                rt = rt >> 1;
            end
            bitv = bitv >> 2;
        end
        return rt[HW-1:0];
    endfunction

    logic [LATENCY-1:0] vld;
    logic [HW-1:0]      dat [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= in_vld;
            for (int i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
        end
    end

    // Data registers only toggle when a token moves through them.
    always_ff @(posedge clk) begin
        if (in_vld) dat[0] <= isqrt_f(a);
        for (int i = 1; i < LATENCY; i++) begin
            if (vld[i-1]) dat[i] <= dat[i-1];
        end
    end

    assign out_vld = vld[LATENCY-1];
    assign y       = {{(WIDTH-HW){1'b0}}, dat[LATENCY-1]};
endmodule

module nested_sqrt_chain_pipe #(
    parameter int N_TERMS       = 3,
    parameter int WIDTH         = 32,
    parameter int ISQRT_LATENCY = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arg_vld,
    input  logic [N_TERMS*WIDTH-1:0] x,
    output logic                     res_vld,
    output logic [WIDTH-1:0]         res,
    output logic                     res_ovf,
    output logic                     busy,
    output logic [$clog2(N_TERMS*ISQRT_LATENCY+N_TERMS+1)-1:0] in_flight
);
    localparam int LAT = N_TERMS * ISQRT_LATENCY + N_TERMS - 1;
    localparam int CW  = $clog2(LAT + 2);

    logic [N_TERMS-1:0]            sq_in_vld;
    logic [N_TERMS-1:0][WIDTH-1:0] sq_in;
    logic [N_TERMS-1:0]            sq_in_ovf;
    logic [N_TERMS-1:0]            sq_out_vld;
    logic [N_TERMS-1:0][WIDTH-1:0] sq_out;
    logic [N_TERMS-1:0]            sq_out_ovf;

    for (genvar j = 0; j < N_TERMS; j++) begin : g_stage
        if (j == 0) begin : g_head
            assign sq_in_vld[0] = arg_vld;
            assign sq_in[0]     = x[(N_TERMS-1)*WIDTH +: WIDTH];
            assign sq_in_ovf[0] = 1'b0;
        end else begin : g_add
            // Operand x[N-1-j] waits until the previous stage's root arrives.
            localparam int DLY = j * (ISQRT_LATENCY + 1) - 1;
            logic [DLY-1:0]   dly_vld;
            logic [WIDTH-1:0] dly_dat [DLY];
            logic [WIDTH:0]   sum;
            logic             add_vld;
            logic             add_ovf;
            logic [WIDTH-1:0] add_dat;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dly_vld <= '0;
                end else begin
                    dly_vld[0] <= arg_vld;
                    for (int i = 1; i < DLY; i++) dly_vld[i] <= dly_vld[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (arg_vld) dly_dat[0] <= x[(N_TERMS-1-j)*WIDTH +: WIDTH];
                for (int i = 1; i < DLY; i++) begin
                    if (dly_vld[i-1]) dly_dat[i] <= dly_dat[i-1];
                end
            end

            assign sum = {1'b0, dly_dat[DLY-1]} + {1'b0, sq_out[j-1]};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    add_vld <= 1'b0;
                    add_ovf <= 1'b0;
                end else begin
                    add_vld <= sq_out_vld[j-1];
                    add_ovf <= sq_out_vld[j-1] & (sq_out_ovf[j-1] | sum[WIDTH]);
                end
            end

            always_ff @(posedge clk) begin
                if (sq_out_vld[j-1]) add_dat <= sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
            end

            a_align : assert property (@(posedge clk) disable iff (rst)
                sq_out_vld[j-1] |-> dly_vld[DLY-1]);

            assign sq_in_vld[j] = add_vld;
            assign sq_in[j]     = add_dat;
            assign sq_in_ovf[j] = add_ovf;
        end

        nested_sqrt_chain_pipe_isqrt #(
            .WIDTH  (WIDTH),
            .LATENCY(ISQRT_LATENCY)
        ) u_isqrt (
            .clk    (clk),
            .rst    (rst),
            .in_vld (sq_in_vld[j]),
            .a      (sq_in[j]),
            .out_vld(sq_out_vld[j]),
            .y      (sq_out[j])
        );

        // Overflow side channel kept in step with the root pipeline.
        logic [ISQRT_LATENCY-1:0] ovf_sh;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ovf_sh <= '0;
            end else begin
                ovf_sh[0] <= sq_in_vld[j] & sq_in_ovf[j];
                for (int i = 1; i < ISQRT_LATENCY; i++) ovf_sh[i] <= ovf_sh[i-1];
            end
        end
        assign sq_out_ovf[j] = ovf_sh[ISQRT_LATENCY-1];
    end

    assign res_vld = sq_out_vld[N_TERMS-1];
    assign res     = sq_out[N_TERMS-1];
    assign res_ovf = sq_out_ovf[N_TERMS-1] & res_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            case ({arg_vld, res_vld})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    assign busy = (in_flight != '0);
endmodule
